// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding types, opcode constants and immediate range limits
// for the instruction encoder and its users.
package instruction_encoder_pkg;

  // One-hot encoding format selector; exactly one flag must be set
  typedef struct packed {
    logic r;
    logic i;
    logic s;
    logic b;
    logic u;
    logic j;
  } EncodingType;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic is_onehot(input EncodingType en);
    logic [5:0] v;
    v = en;
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/instruction_encoder_sync_fifo.sv
// Small synchronous FIFO with registered storage; head is presented
// directly from storage so outputs hold while the consumer stalls.
module sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instruction_encoder.sv
// Packs opcode/funct/register/immediate fields into RV32I words, range-checks
// the immediate, stamps a program address and buffers results in a FIFO.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  EncodingType       in_en,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count,
  input  logic              err_clear
);

  localparam int unsigned WIDTH = 32 + ADDR_W + 1;

  logic              push;
  logic              pop;
  logic              full;
  logic [31:0]       inst_c;
  logic              err_c;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stamp_c;
  logic signed [31:0] imm_s;

  assign imm_s = in_imm;

  // Field packing and immediate range check
  always_comb begin
    inst_c = NOP_INST;
    err_c  = 1'b0;
    if (!is_onehot(in_en)) begin
      err_c = 1'b1;
    end else if (in_en.r) begin
      inst_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    end else if (in_en.i) begin
      err_c  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      inst_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
    end else if (in_en.s) begin
      err_c  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      inst_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
    end else if (in_en.b) begin
      err_c  = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX) || in_imm[0];
      inst_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                in_imm[4:1], in_imm[11], in_opcode};
    end else if (in_en.u) begin
      err_c  = (in_imm[11:0] != 12'd0);
      inst_c = {in_imm[31:12], in_rd, in_opcode};
    end else begin
      err_c  = (imm_s < IMM21_MIN) || (imm_s > IMM21_MAX) || in_imm[0];
      inst_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
    end
    if (err_c) inst_c = NOP_INST;
  end

  assign pop      = out_valid & out_ready;
  assign in_ready = ~full | pop;
  assign push     = in_valid & in_ready;
  assign stamp_c  = load_base ? base_addr : addr_q;

  // Program address counter; a coincident load stamps the new base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (push) begin
      addr_q <= stamp_c + ADDR_W'(4);
    end else if (load_base) begin
      addr_q <= base_addr;
    end
  end

  // Saturating error counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (err_clear) begin
      err_count <= 8'd0;
    end else if (push && err_c && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({inst_c, stamp_c, err_c}),
    .full  (full),
    .pop   (pop),
    .rdata ({out_inst, out_addr, out_err}),
    .valid (out_valid)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: vector table through a
// scoreboard plus directed backpressure, base-load and reset sequences.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  EncodingType in_en;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        load_base;
  logic [31:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;
  logic        err_clear;

  instruction_encoder #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_en(in_en), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .load_base(load_base), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] EN_R = 6'b100000;
  localparam logic [5:0] EN_I = 6'b010000;
  localparam logic [5:0] EN_S = 6'b001000;
  localparam logic [5:0] EN_B = 6'b000100;
  localparam logic [5:0] EN_U = 6'b000010;
  localparam logic [5:0] EN_J = 6'b000001;

  typedef struct {
    logic [5:0]  en;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  int          exp_errcnt;
  logic [31:0] held;

  function automatic vec_t mk(input logic [5:0] en, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] inst, input logic err);
    vec_t v;
    v.en = en; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.imm = imm; v.inst = inst; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Compare the FIFO head against the scoreboard whenever it is consumed
  task automatic monitor();
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got inst %h addr %h, expected nothing", out_inst, out_addr);
      end else begin
        e = sb.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_addr", out_addr, e.addr);
        chk("out_err", 32'(out_err), 32'(e.err));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input vec_t v, input logic lb, input logic [31:0] ba);
    logic        acc;
    int          n;
    logic [31:0] stamp;
    in_valid = 1'b1; in_en = EncodingType'(v.en); in_opcode = v.op;
    in_funct3 = v.f3; in_funct7 = v.f7; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_imm = v.imm; load_base = lb; base_addr = ba;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      monitor();
      acc = in_ready;
      if (acc) begin
        stamp = lb ? ba : exp_addr;
        sb.push_back('{v.inst, stamp, v.err});
        exp_addr = stamp + 32'd4;
        if (err_clear) exp_errcnt = 0;
        else if (v.err && exp_errcnt < 255) exp_errcnt++;
      end else if (lb) begin
        exp_addr = ba;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready %b after %0d cycles, expected 1", in_ready, n);
    end
    in_valid = 1'b0;
    load_base = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t ev;
    rst_n = 1'b0; in_valid = 1'b0; in_en = EncodingType'(6'd0); in_opcode = '0;
    in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; load_base = 1'b0; base_addr = '0; out_ready = 1'b1;
    err_clear = 1'b0; exp_addr = '0; exp_errcnt = 0;

    vecs.push_back(mk(EN_I, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0));
    vecs.push_back(mk(EN_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0));
    vecs.push_back(mk(EN_U, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0));
    vecs.push_back(mk(EN_J, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h0010_00EF, 1'b0));
    vecs.push_back(mk(EN_J, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3,         32'h0000_0013, 1'b1));
    vecs.push_back(mk(EN_R, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd5,         32'h4020_81B3, 1'b0));
    vecs.push_back(mk(EN_S, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 1'b0));
    vecs.push_back(mk(EN_S, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_F800, 32'h8020_A023, 1'b0));
    vecs.push_back(mk(EN_I, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd2047,      32'h7FF1_0093, 1'b0));
    vecs.push_back(mk(EN_I, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 32'h8001_0093, 1'b0));
    vecs.push_back(mk(EN_I, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd2048,      32'h0000_0013, 1'b1));
    vecs.push_back(mk(EN_S, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(EN_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4094,      32'h7E20_8FE3, 1'b0));
    vecs.push_back(mk(EN_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096,      32'h0000_0013, 1'b1));
    vecs.push_back(mk(EN_B, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd5,         32'h0000_0013, 1'b1));
    vecs.push_back(mk(EN_J, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000_00EF, 1'b0));
    vecs.push_back(mk(EN_J, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(EN_U, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(6'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0,         32'h0000_0013, 1'b1));
    vecs.push_back(mk(6'b010100, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0,    32'h0000_0013, 1'b1));
    ev = vecs[4];

    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_out_addr", out_addr, 32'd0);
    chk("reset_out_err", 32'(out_err), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    apply(vecs[0], 1'b0, 32'd0);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i < vecs.size(); i++) apply(vecs[i], 1'b0, 32'd0);
    drain();
    chk("err_count_table", 32'(err_count), 32'(exp_errcnt));

    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    exp_errcnt = 0;
    chk("err_clear", 32'(err_count), 32'd0);

    for (int i = 0; i < 258; i++) apply(ev, 1'b0, 32'd0);
    drain();
    chk("err_count_saturate", 32'(err_count), 32'd255);
    err_clear = 1'b1;
    apply(ev, 1'b0, 32'd0);
    err_clear = 1'b0;
    chk("err_clear_priority", 32'(err_count), 32'd0);
    drain();

    // Backpressure after a fresh reset: two entries fill the FIFO
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sb.delete();
    exp_addr = '0;
    exp_errcnt = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    apply(vecs[0], 1'b0, 32'd0);
    apply(vecs[1], 1'b0, 32'd0);
    in_valid = 1'b1;
    in_en = EncodingType'(vecs[2].en);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    held = out_inst;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("hold_out_inst", out_inst, held);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    apply(vecs[2], 1'b0, 32'd0);
    drain();

    apply(vecs[5], 1'b1, 32'h0000_1000);
    apply(vecs[6], 1'b0, 32'd0);
    apply(vecs[3], 1'b1, 32'hFFFF_FFFC);
    apply(vecs[0], 1'b0, 32'd0);
    drain();
    chk("wrap_exp_addr", exp_addr, 32'd4);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    apply(vecs[0], 1'b0, 32'd0);
    apply(ev, 1'b0, 32'd0);
    chk("pre_reset_err_count", 32'(err_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = '0;
    exp_errcnt = 0;
    @(posedge clk);
    #1;
    chk("post_reset_err_count", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    apply(vecs[0], 1'b0, 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
